// File: rtl/down_counter.sv
// Loadable down-counter / timer with a start/done/ack handshake.
// The period register remembers the last loaded value so that auto-reload
// mode can restart the count for periodic ticks without control-unit help.
module down_counter #(
    parameter int unsigned      width       = 8,
    parameter logic [width-1:0] init_value  = 8'hff,
    parameter bit               auto_reload = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [width-1:0] load_value,
    input  logic             start,
    input  logic             c_down,
    input  logic             ack,
    output logic [width-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [width-1:0] ONE = width'(1);

    state_t           state, state_nxt;
    logic [width-1:0] period, period_nxt;
    logic [width-1:0] q_nxt;
    logic             done_nxt;

    // Next-state, next-count and done-pulse decode for the RUN/DONE handshake.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_nxt  = state;
        q_nxt      = q;
        period_nxt = period;
        done_nxt   = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (load) begin
                    // load beats start: start must be reasserted afterwards
                    q_nxt      = load_value;
                    period_nxt = load_value;
                end else if (start) begin
                    if (q == '0) begin
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                if (q == '0) begin
                    // defensive: a zero count in RUN never decrements
                    state_nxt = ST_DONE;
                    done_nxt  = 1'b1;
                end else if (c_down) begin
                    if (q > ONE) begin
                        q_nxt = q - ONE;
                    end else if (auto_reload && (period != '0)) begin
                        // periodic tick: restart from period, pulse done once
                        q_nxt    = period;
                        done_nxt = 1'b1;
                    end else begin
                        q_nxt     = '0;
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                if (ack) begin
                    state_nxt = ST_IDLE;
                end else begin
                    done_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, count, period and done registers with synchronous reset/clear.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (rst || clear) begin
            state  <= ST_IDLE;
            q      <= init_value;
            period <= init_value;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            q      <= q_nxt;
            period <= period_nxt;
            done   <= done_nxt;
        end
    end

    // busy decodes the state register; tc is a purely combinational zero flag.
    assign busy = (state == ST_RUN);
    assign tc   = (q == '0);

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter: one one-shot instance and one
// auto-reload instance share the stimulus; each scenario checks one of them.
module tb_down_counter;

    typedef struct packed {
        logic [7:0] q;
        logic       busy;
        logic       done;
        logic       tc;
    } obs_t;

    typedef struct {
        logic       rst;
        logic       clear;
        logic       load;
        logic [7:0] lv;
        logic       start;
        logic       c_down;
        logic       ack;
        obs_t       exp;
    } step_t;

    logic       clk = 1'b0;
    logic       rst, clear, load, start, c_down, ack;
    logic [7:0] load_value;
    logic [7:0] q0, q1;
    logic       busy0, done0, tc0, busy1, done1, tc1;

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];

    always #5 clk = ~clk;

    down_counter #(.width(8), .init_value(8'hff), .auto_reload(1'b0)) dut0 (
        .clk(clk), .rst(rst), .clear(clear), .load(load), .load_value(load_value),
        .start(start), .c_down(c_down), .ack(ack),
        .q(q0), .busy(busy0), .done(done0), .tc(tc0)
    );

    down_counter #(.width(8), .init_value(8'hff), .auto_reload(1'b1)) dut1 (
        .clk(clk), .rst(rst), .clear(clear), .load(load), .load_value(load_value),
        .start(start), .c_down(c_down), .ack(ack),
        .q(q1), .busy(busy1), .done(done1), .tc(tc1)
    );

    function automatic step_t mk(input logic r, input logic c, input logic l,
                                 input logic [7:0] v, input logic s, input logic d,
                                 input logic a, input logic [7:0] eq, input logic eb,
                                 input logic ed, input logic et);
        step_t st;
        st.rst = r; st.clear = c; st.load = l; st.lv = v;
        st.start = s; st.c_down = d; st.ack = a;
        st.exp = {eq, eb, ed, et};
        return st;
    endfunction

    task automatic apply(input step_t st);
        rst        = st.rst;
        clear      = st.clear;
        load       = st.load;
        load_value = st.lv;
        start      = st.start;
        c_down     = st.c_down;
        ack        = st.ack;
    endtask

    task automatic test_reset();
        obs_t e, o0, o1;
        for (int i = 0; i < 2; i++) begin
            rst        = 1'b1;
            clear      = 1'($urandom_range(1));
            load       = 1'($urandom_range(1));
            load_value = 8'($urandom_range(255));
            start      = 1'($urandom_range(1));
            c_down     = 1'($urandom_range(1));
            ack        = 1'($urandom_range(1));
            exp_q.push_back({8'hff, 1'b0, 1'b0, 1'b0});
            @(posedge clk); #1;
            e  = exp_q.pop_front();
            o0 = {q0, busy0, done0, tc0};
            o1 = {q1, busy1, done1, tc1};
            checks++;
            if (o0 !== e) begin
                errors++;
                $display("FAIL reset[%0d] one-shot: got q=%h busy=%b done=%b tc=%b, want q=%h busy=%b done=%b tc=%b",
                         i, o0.q, o0.busy, o0.done, o0.tc, e.q, e.busy, e.done, e.tc);
            end
            checks++;
            if (o1 !== e) begin
                errors++;
                $display("FAIL reset[%0d] reload: got q=%h busy=%b done=%b tc=%b, want q=%h busy=%b done=%b tc=%b",
                         i, o1.q, o1.busy, o1.done, o1.tc, e.q, e.busy, e.done, e.tc);
            end
        end
    endtask

    task automatic test_basic();
        step_t tbl[$];
        obs_t  e, o;
        tbl.push_back(mk(0,0,1,8'd3,0,0,0, 8'd3,0,0,0));
        tbl.push_back(mk(0,0,0,8'd0,1,1,0, 8'd3,1,0,0));
        tbl.push_back(mk(0,0,0,8'd0,0,1,0, 8'd2,1,0,0));
        tbl.push_back(mk(0,0,0,8'd0,0,1,0, 8'd1,1,0,0));
        tbl.push_back(mk(0,0,0,8'd0,0,1,0, 8'd0,0,1,1));
        tbl.push_back(mk(0,0,0,8'd0,1,0,0, 8'd0,0,1,1));
        tbl.push_back(mk(0,0,0,8'd0,0,0,1, 8'd0,0,0,1));
        foreach (tbl[i]) begin
            apply(tbl[i]);
            exp_q.push_back(tbl[i].exp);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            o = {q0, busy0, done0, tc0};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL basic[%0d]: got q=%h busy=%b done=%b tc=%b, want q=%h busy=%b done=%b tc=%b",
                         i, o.q, o.busy, o.done, o.tc, e.q, e.busy, e.done, e.tc);
            end
        end
    endtask

    task automatic test_stall();
        step_t tbl[$];
        obs_t  e, o;
        tbl.push_back(mk(0,0,1,8'd5,0,0,0, 8'd5,0,0,0));
        tbl.push_back(mk(0,0,0,8'd0,1,0,0, 8'd5,1,0,0));
        tbl.push_back(mk(0,0,0,8'd0,0,1,0, 8'd4,1,0,0));
        tbl.push_back(mk(0,0,0,8'd0,0,0,0, 8'd4,1,0,0));
        tbl.push_back(mk(0,0,0,8'd0,0,1,0, 8'd3,1,0,0));
        tbl.push_back(mk(0,0,0,8'd0,0,0,0, 8'd3,1,0,0));
        tbl.push_back(mk(0,0,1,8'h40,1,0,0, 8'd3,1,0,0));
        tbl.push_back(mk(0,0,0,8'd0,0,1,0, 8'd2,1,0,0));
        tbl.push_back(mk(0,0,0,8'd0,0,1,0, 8'd1,1,0,0));
        tbl.push_back(mk(0,0,0,8'd0,0,1,0, 8'd0,0,1,1));
        tbl.push_back(mk(0,0,0,8'd0,0,0,1, 8'd0,0,0,1));
        tbl.push_back(mk(0,0,1,8'd7,1,0,0, 8'd7,0,0,0));
        tbl.push_back(mk(0,0,0,8'd0,0,1,0, 8'd7,0,0,0));
        tbl.push_back(mk(0,0,0,8'd0,0,1,1, 8'd7,0,0,0));
        foreach (tbl[i]) begin
            apply(tbl[i]);
            exp_q.push_back(tbl[i].exp);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            o = {q0, busy0, done0, tc0};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL stall[%0d]: got q=%h busy=%b done=%b tc=%b, want q=%h busy=%b done=%b tc=%b",
                         i, o.q, o.busy, o.done, o.tc, e.q, e.busy, e.done, e.tc);
            end
        end
    endtask

    task automatic test_boundary();
        step_t tbl[$];
        obs_t  e, o;
        tbl.push_back(mk(0,0,1,8'd0,0,0,0, 8'd0,0,0,1));
        tbl.push_back(mk(0,0,0,8'd0,1,0,0, 8'd0,0,1,1));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(0,0,0,8'd0,0,1,0, 8'd0,0,1,1));
        tbl.push_back(mk(0,0,0,8'd0,0,1,1, 8'd0,0,0,1));
        tbl.push_back(mk(0,0,0,8'd0,1,1,0, 8'd0,0,1,1));
        tbl.push_back(mk(0,0,0,8'd0,0,0,1, 8'd0,0,0,1));
        foreach (tbl[i]) begin
            apply(tbl[i]);
            exp_q.push_back(tbl[i].exp);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            o = {q0, busy0, done0, tc0};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL boundary[%0d]: got q=%h busy=%b done=%b tc=%b, want q=%h busy=%b done=%b tc=%b",
                         i, o.q, o.busy, o.done, o.tc, e.q, e.busy, e.done, e.tc);
            end
        end
    endtask

    task automatic test_clear();
        step_t tbl[$];
        obs_t  e, o;
        tbl.push_back(mk(0,0,1,8'd10,0,0,0, 8'd10,0,0,0));
        tbl.push_back(mk(0,0,0,8'd0,1,1,0, 8'd10,1,0,0));
        for (int k = 9; k >= 6; k--)
            tbl.push_back(mk(0,0,0,8'd0,0,1,0, 8'(k),1,0,0));
        tbl.push_back(mk(0,1,0,8'd0,0,1,0, 8'hff,0,0,0));
        tbl.push_back(mk(0,0,0,8'd0,0,1,0, 8'hff,0,0,0));
        tbl.push_back(mk(0,0,1,8'd1,0,0,0, 8'd1,0,0,0));
        tbl.push_back(mk(0,0,0,8'd0,1,1,0, 8'd1,1,0,0));
        tbl.push_back(mk(0,0,0,8'd0,0,1,0, 8'd0,0,1,1));
        tbl.push_back(mk(0,1,0,8'd0,0,0,0, 8'hff,0,0,0));
        tbl.push_back(mk(0,1,1,8'd5,1,0,0, 8'hff,0,0,0));
        foreach (tbl[i]) begin
            apply(tbl[i]);
            exp_q.push_back(tbl[i].exp);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            o = {q0, busy0, done0, tc0};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL clear[%0d]: got q=%h busy=%b done=%b tc=%b, want q=%h busy=%b done=%b tc=%b",
                         i, o.q, o.busy, o.done, o.tc, e.q, e.busy, e.done, e.tc);
            end
        end
    endtask

    task automatic test_auto_reload();
        step_t      tbl[$];
        obs_t       e, o;
        logic [7:0] prev;
        tbl.push_back(mk(0,1,0,8'd0,0,0,0, 8'hff,0,0,0));
        tbl.push_back(mk(0,0,1,8'd2,0,0,0, 8'd2,0,0,0));
        tbl.push_back(mk(0,0,0,8'd0,1,1,0, 8'd2,1,0,0));
        for (int k = 0; k < 3; k++) begin
            tbl.push_back(mk(0,0,0,8'd0,0,1,0, 8'd1,1,0,0));
            tbl.push_back(mk(0,0,0,8'd0,0,1,0, 8'd2,1,1,0));
        end
        tbl.push_back(mk(0,0,0,8'd0,0,0,0, 8'd2,1,0,0));
        tbl.push_back(mk(0,1,0,8'd0,0,0,0, 8'hff,0,0,0));
        tbl.push_back(mk(0,0,1,8'd0,0,0,0, 8'd0,0,0,1));
        tbl.push_back(mk(0,0,0,8'd0,1,0,0, 8'd0,0,1,1));
        tbl.push_back(mk(0,0,0,8'd0,0,0,1, 8'd0,0,0,1));
        // after clear the period must be all-ones: count a full lap and reload
        tbl.push_back(mk(0,1,0,8'd0,0,0,0, 8'hff,0,0,0));
        tbl.push_back(mk(0,0,0,8'd0,1,1,0, 8'hff,1,0,0));
        prev = 8'hff;
        for (int k = 0; k < 256; k++) begin
            if (prev == 8'd1) begin
                tbl.push_back(mk(0,0,0,8'd0,0,1,0, 8'hff,1,1,0));
                prev = 8'hff;
            end else begin
                tbl.push_back(mk(0,0,0,8'd0,0,1,0, prev - 8'd1,1,0,(prev == 8'd1)));
                prev = prev - 8'd1;
            end
        end
        tbl.push_back(mk(0,1,0,8'd0,0,0,0, 8'hff,0,0,0));
        foreach (tbl[i]) begin
            apply(tbl[i]);
            exp_q.push_back(tbl[i].exp);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            o = {q1, busy1, done1, tc1};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL auto_reload[%0d]: got q=%h busy=%b done=%b tc=%b, want q=%h busy=%b done=%b tc=%b",
                         i, o.q, o.busy, o.done, o.tc, e.q, e.busy, e.done, e.tc);
            end
        end
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; load = 1'b0; load_value = 8'd0;
        start = 1'b0; c_down = 1'b0; ack = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_boundary();
        test_clear();
        test_auto_reload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/down_counter.md
Name: down_counter

Overview:
- Loadable down-counter / timer. Counterpart to the team's up-counter: it counts toward zero instead of up from an initial value.
- The control unit loads a period, starts the block, and waits for done. Used for sequencing multi-cycle datapath operations such as iterative multiply/divide step counts.
- Small RUN/DONE FSM with a start/done/ack handshake and optional auto-reload for periodic ticks.

Parameters:
- width, 8, bit width of the count and load value.
- init_value, 8'hff, value of q and of the period register after rst or clear.
- auto_reload, 0. When 1, reaching zero reloads the period and keeps running instead of waiting for ack.

Ports:
- clk  input  1  clock; all state updates on posedge clk.
- rst  input  1  reset, synchronous, active-high.
- clear  input  1  synchronous soft clear: same effect as rst.
- load  input  1  in IDLE, captures load_value into q and the period register.
- load_value  input  width  value captured by load.
- start  input  1  in IDLE, begins counting (IDLE->RUN).
- c_down  input  1  count enable while in RUN.
- ack  input  1  acknowledges done in DONE (DONE->IDLE).
- q  output  width  current count, registered.
- busy  output  1  high while state==RUN, decoded from the state register.
- done  output  1  high in DONE; one-cycle registered pulse per zero crossing when auto_reload=1.
- tc  output  1  combinational terminal count, q==0.

Behaviour:
- Reset:
  - rst is synchronous, active-high, evaluated only on posedge clk.
  - On reset: state=IDLE, q=init_value, period=init_value, busy=0, done=0, tc=(init_value==0).
- Priority at each posedge: rst > clear > state-specific actions. clear is identical to rst in effect, including mid-RUN and in DONE.
- IDLE:
  - load=1: q<=load_value, period<=load_value.
  - start=1 with load=0: go to RUN. If q==0, go to DONE instead and skip RUN.
  - load=1 and start=1 in the same cycle: load wins, start is ignored and must be reasserted.
  - c_down and ack are ignored.
- RUN:
  - c_down=1 and q>1: q<=q-1.
  - c_down=1 and q==1: q<=0. If auto_reload=0, next state is DONE.
  - If auto_reload=1 instead: q<=period (or 0 if period==0, which then goes to DONE), state stays RUN, and done pulses high for exactly that next cycle.
  - c_down=0: q holds.
  - load and start are ignored in RUN.
- DONE:
  - q holds at 0, done=1, busy=0.
  - ack=1: go to IDLE and done<=0 on the same edge; q stays 0.
  - start in DONE is ignored.
  - A new period needs load in IDLE; otherwise start from IDLE with q==0 returns directly to DONE.
- Arithmetic:
  - Unsigned, width bits.
  - q never decrements below 0: no wrap to all-ones under any input combination.
- Latency:
  - Starting with q=N (N>=1) and c_down held high, DONE is entered N cycles after the edge that accepted start, and done is visible on cycle N+1.
  - A load takes effect on q the cycle after the edge.

Test Plan:
- Reset: assert rst for 2 cycles with random inputs -> q=8'hff, busy=0, done=0, tc=0. With rst high, clear/load/start have no effect.
- Basic countdown: load 8'h03, start, c_down=1 -> q 3,2,1,0 on successive edges, busy high for 3 cycles, done=1 and tc=1 at q=0; ack -> IDLE, done=0.
- Stall and simultaneous events: load 5, start, toggle c_down 1,0,1,0 -> q 5,4,4,3,3. load+start in the same cycle in IDLE -> q=load_value, stays IDLE. load during RUN -> ignored.
- Boundary:
  - load 0 then start -> DONE the next cycle, q stays 0, no underflow.
  - In DONE with c_down held high for 5 cycles -> q remains 0.
- Clear mid-operation: load 10, start, count to 6, assert clear -> next cycle q=8'hff, state IDLE, busy=0, done=0, period=8'hff.
- auto_reload=1: load 2, start, c_down=1 for 7 cycles -> q 2,1,2,1,2,1,2 with a single-cycle done pulse after each 1->reload transition; busy stays 1 throughout.
